// File: rtl/multi_operand_accumulator.sv
// Streams 1..MAX_OPS operands (one per cycle) plus carry-in into a widened accumulator; out_valid
// rises on the edge that accepts the last operand. Operands stall on in_valid=0; the result holds while out_ready=0.
module multi_operand_accumulator #(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 8,
    parameter int CNT_W   = 4,
    parameter int EXT_W   = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] op_count,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [EXT_W-1:0] sum_hi,
    output logic             cout,
    output logic             busy
);

    localparam int ACC_W = WIDTH + EXT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   n_sel;

    // Oversized requests are clamped rather than rejected.
    assign n_sel = (op_count > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : op_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_sel == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && remaining == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= ACC_W'(cin);
                        remaining <= n_sel;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc       <= acc + {{EXT_W{1'b0}}, operand};
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state/acc only, so no input reaches an output combinationally.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        busy      = (state == ACCUM) || (state == DONE);
        result    = acc[WIDTH-1:0];
        sum_hi    = acc[ACC_W-1:WIDTH];
        cout      = |acc[ACC_W-1:WIDTH];
    end

endmodule

// File: tb/tb_multi_operand_accumulator.sv
module tb_multi_operand_accumulator;

    localparam int WIDTH   = 32;
    localparam int MAX_OPS = 8;
    localparam int CNT_W   = 4;
    localparam int EXT_W   = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             cin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [EXT_W-1:0] sum_hi;
    logic             cout;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] ops [16];
    logic [WIDTH-1:0] got_result;
    logic [EXT_W-1:0] got_hi;

    always #5 clk = ~clk;

    multi_operand_accumulator #(
        .WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W), .EXT_W(EXT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .op_count(op_count), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready), .operand(operand),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .sum_hi(sum_hi), .cout(cout), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " in_ready"},  64'(in_ready),  64'd0);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " result"},    64'(result),    64'd0);
        check({tag, " sum_hi"},    64'(sum_hi),    64'd0);
        check({tag, " cout"},      64'(cout),      64'd0);
    endtask

    // One complete sum. stall_pct<0 selects the fixed valid pattern 1,0,0,1,0,1.
    // All stimulus changes and sampling happen on the falling edge.
    task automatic do_sum(input int cnt, input bit c, input int stall_pct,
                          input int hold, input bit poke);
        int         n;
        int         accepted;
        int         stalls;
        int         iter;
        bit         xfer;
        logic [63:0] ref_sum;
        logic [5:0]  pat;
        pat = 6'b101001;
        n = (cnt > MAX_OPS) ? MAX_OPS : cnt;
        ref_sum = 64'(c);
        for (int i = 0; i < n; i++) ref_sum += 64'(ops[i]);
        ref_sum &= (64'd1 << (WIDTH + EXT_W)) - 64'd1;

        check("idle out_valid", 64'(out_valid), 64'd0);
        check("idle in_ready", 64'(in_ready), 64'd0);
        start = 1'b1; op_count = CNT_W'(cnt); cin = c;
        @(negedge clk);
        start = 1'b0;

        accepted = 0; stalls = 0; iter = 0;
        while (!out_valid && iter < 200) begin
            check("accum in_ready", 64'(in_ready), 64'd1);
            check("accum busy", 64'(busy), 64'd1);
            if (stall_pct < 0) in_valid = (iter < 6) ? pat[iter] : 1'b1;
            else               in_valid = ($urandom_range(0, 99) >= stall_pct);
            operand = ops[accepted];
            start   = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!in_valid) stalls++;
            xfer = in_valid && in_ready;
            @(negedge clk);
            if (xfer) accepted++;
            iter++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (iter >= 200) check("out_valid timeout", 64'(iter), 64'd0);
        check("operands accepted", 64'(accepted), 64'(n));
        check("latency", 64'(iter), 64'(n + stalls));

        for (int h = 0; h <= hold; h++) begin
            check("done out_valid", 64'(out_valid), 64'd1);
            check("done in_ready", 64'(in_ready), 64'd0);
            check("done busy", 64'(busy), 64'd1);
            check("result", 64'(result), 64'(ref_sum[WIDTH-1:0]));
            check("sum_hi", 64'(sum_hi), 64'(ref_sum[WIDTH+EXT_W-1:WIDTH]));
            check("cout", 64'(cout), 64'(|ref_sum[WIDTH+EXT_W-1:WIDTH]));
            got_result = result;
            got_hi     = sum_hi;
            start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (h == hold);
            @(negedge clk);
        end
        out_ready = 1'b0;
        start     = 1'b0;
        check("back to idle busy", 64'(busy), 64'd0);
        check("back to idle out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; op_count = '0; cin = 1'b0;
        in_valid = 1'b0; operand = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Legacy 5-input adder case.
        for (int i = 0; i < 16; i++) ops[i] = WIDTH'(i + 1);
        do_sum(5, 1'b1, 0, 0, 1'b0);
        check("basic literal", 64'(got_result), 64'd16);

        for (int i = 0; i < 16; i++) ops[i] = '1;
        do_sum(3, 1'b1, 0, 2, 1'b0);
        check("ovf3 literal result", 64'(got_result), 64'hFFFF_FFFE);
        check("ovf3 literal hi", 64'(got_hi), 64'd2);
        do_sum(8, 1'b1, 0, 0, 1'b0);
        check("ovf8 literal result", 64'(got_result), 64'hFFFF_FFF9);
        check("ovf8 literal hi", 64'(got_hi), 64'd7);

        do_sum(0, 1'b1, 0, 0, 1'b0);
        check("zero literal", 64'(got_result), 64'd1);
        for (int i = 0; i < 16; i++) ops[i] = WIDTH'(100 * (i + 1));
        do_sum(15, 1'b0, 0, 0, 1'b0);
        check("clamp literal", 64'(got_result), 64'd3600);

        ops[0] = 32'd10; ops[1] = 32'd20; ops[2] = 32'd30;
        do_sum(3, 1'b0, -1, 4, 1'b1);
        check("stall literal", 64'(got_result), 64'd60);

        // Abandon a sum halfway through.
        start = 1'b1; op_count = 4'd4; cin = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; operand = 32'h1234_5678;
        repeat (2) @(negedge clk);
        in_valid = 1'b0; resetn = 1'b0;
        @(negedge clk);
        check_idle_zero("mid reset");
        resetn = 1'b1;
        @(negedge clk);
        ops[0] = 32'd7; ops[1] = 32'd8;
        do_sum(2, 1'b0, 0, 0, 1'b0);
        check("post reset literal", 64'(got_result), 64'd15);

        // Randomized back-to-back sums against the reference sum.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++)
                ops[i] = ($urandom_range(0, 3) == 0) ? '1 : WIDTH'($urandom);
            do_sum($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 50), $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
